// File: rtl/tmds_encoder_3ch_pkg.sv
// tmds_pkg: shared constants, types and helpers for the three-channel
// TMDS encoder.
//   CTRL_TOKEN[c]      10-bit control characters, indexed by {c1,c0}
//   GB_CH0..GB_CH2     video leading guard-band characters per channel
//   PREAMBLE_LEN/GUARD_LEN and the derived phase-counter load value
//   sel_t / stage1_t   per-channel stage-1 pipeline bundle
//   ones8 / minimise   popcount and transition-minimising first stage
package tmds_pkg;

    // Element [i] is the token for {c1,c0} == i.
    localparam logic [3:0][9:0] CTRL_TOKEN = {
        10'b1010101011,   // 11
        10'b0101010100,   // 10
        10'b0010101011,   // 01
        10'b1101010100    // 00
    };

    localparam logic [9:0] GB_CH0 = 10'b1011001100;
    localparam logic [9:0] GB_CH1 = 10'b0100110011;
    localparam logic [9:0] GB_CH2 = 10'b1011001100;

    localparam int unsigned PREAMBLE_LEN = 8;
    localparam int unsigned GUARD_LEN    = 2;
    localparam int unsigned DELAY_LEN    = PREAMBLE_LEN + GUARD_LEN;

    localparam logic [3:0] PHASE_LOAD    = 4'(DELAY_LEN);
    localparam logic [3:0] GUARD_PHASES  = 4'(GUARD_LEN);

    typedef enum logic [1:0] {
        SEL_VIDEO = 2'd0,
        SEL_CTRL  = 2'd1,
        SEL_GUARD = 2'd2
    } sel_t;

    typedef struct packed {
        logic [8:0] q_m;
        logic       de;
        logic [1:0] ctrl;
        sel_t       sel;
    } stage1_t;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // q_m[8] = 1 marks the XOR chain, 0 the XNOR chain.
    function automatic logic [8:0] minimise(input logic [7:0] d);
        logic [8:0] q;
        logic [3:0] n1;
        logic       use_xnor;
        n1       = ones8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int unsigned i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

endpackage

// File: rtl/tmds_encoder_3ch_if.sv
// tmds_encoder_3ch_if: pixel input and TMDS character output bundle.
//   i_hve       [0] hsync, [1] vsync, [2] display enable
//   i_rgb       {R[23:16], G[15:8], B[7:0]}
//   o_tmds_ch0  blue / sync channel character, bit 0 serialised first
//   o_tmds_ch1  green channel character
//   o_tmds_ch2  red channel character
// master: pixel source side; slave: encoder side.
interface tmds_encoder_3ch_if;
    logic [2:0]  i_hve;
    logic [23:0] i_rgb;
    logic [9:0]  o_tmds_ch0;
    logic [9:0]  o_tmds_ch1;
    logic [9:0]  o_tmds_ch2;

    modport master (
        output i_hve,
        output i_rgb,
        input  o_tmds_ch0,
        input  o_tmds_ch1,
        input  o_tmds_ch2
    );

    modport slave (
        input  i_hve,
        input  i_rgb,
        output o_tmds_ch0,
        output o_tmds_ch1,
        output o_tmds_ch2
    );
endinterface

// File: rtl/tmds_encoder_3ch_channel.sv
// tmds_channel: one TMDS channel, two pipeline stages.
//   clk, reset  pixel clock, synchronous active-high reset
//   data        8-bit pixel component
//   de          display enable for this cycle
//   ctrl        control bits {c1,c0} used when not video
//   sel         video / control / guard select
//   tmds        registered 10-bit character
// Stage 1 registers the transition-minimised word with its side-band;
// stage 2 applies DC balance against the running disparity cnt.
module tmds_channel
    import tmds_pkg::*;
#(
    parameter logic [9:0] GUARD_CHAR = GB_CH0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       de,
    input  logic [1:0] ctrl,
    input  sel_t       sel,
    output logic [9:0] tmds
);

    stage1_t           s1;
    logic signed [4:0] cnt;
    logic signed [4:0] cnt_next;
    logic [9:0]        char_next;
    logic [3:0]        n1m;
    logic [3:0]        n0m;
    logic signed [4:0] diff;
    logic signed [4:0] two_q8;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1.q_m  <= '0;
            s1.de   <= 1'b0;
            s1.ctrl <= '0;
            s1.sel  <= SEL_CTRL;
        end else begin
            s1.q_m  <= minimise(data);
            s1.de   <= de;
            s1.ctrl <= ctrl;
            s1.sel  <= sel;
        end
    end

    always_comb begin
        n1m       = ones8(s1.q_m[7:0]);
        n0m       = 4'd8 - n1m;
        diff      = $signed({1'b0, n1m}) - $signed({1'b0, n0m});
        two_q8    = s1.q_m[8] ? 5'sd2 : 5'sd0;
        char_next = CTRL_TOKEN[s1.ctrl];
        cnt_next  = '0;
        if (s1.de) begin
            if ((cnt == 5'sd0) || (n1m == n0m)) begin
                char_next = {~s1.q_m[8], s1.q_m[8],
                             s1.q_m[8] ? s1.q_m[7:0] : ~s1.q_m[7:0]};
                cnt_next  = s1.q_m[8] ? (cnt + diff) : (cnt - diff);
            end else if (((cnt > 5'sd0) && (n1m > n0m)) ||
                         ((cnt < 5'sd0) && (n0m > n1m))) begin
                char_next = {1'b1, s1.q_m[8], ~s1.q_m[7:0]};
                cnt_next  = cnt + two_q8 - diff;
            end else begin
                char_next = {1'b0, s1.q_m[8], s1.q_m[7:0]};
                cnt_next  = cnt - (5'sd2 - two_q8) + diff;
            end
        end else if (s1.sel == SEL_GUARD) begin
            char_next = GUARD_CHAR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            tmds <= CTRL_TOKEN[0];
        end else begin
            cnt  <= cnt_next;
            tmds <= char_next;
        end
    end

endmodule

// File: rtl/tmds_encoder_3ch.sv
// tmds_encoder_3ch: three-channel DVI/HDMI TMDS encoder.
//   hdmi_clk  pixel clock
//   reset     synchronous active-high reset
//   vid       slave side of tmds_encoder_3ch_if (i_hve, i_rgb in;
//             o_tmds_ch0..2 out)
// VIDEO_GUARD = 1 delays the pixel stream by ten cycles so that the
// video preamble and leading guard band can be inserted ahead of each
// DE rise seen at the undelayed input. VIDEO_GUARD = 0 is plain DVI.
module tmds_encoder_3ch
    import tmds_pkg::*;
#(
    parameter bit VIDEO_GUARD = 1'b1
) (
    input  logic                hdmi_clk,
    input  logic                reset,
    tmds_encoder_3ch_if.slave   vid
);

    logic [2:0]  hve_d;
    logic [23:0] rgb_d;
    logic [3:0]  phase;
    sel_t        sel;
    logic [1:0]  ctl_g;

    generate
        if (VIDEO_GUARD) begin : g_guard
            logic [DELAY_LEN-1:0][26:0] dly;
            logic                       prev_de;
            logic [3:0]                 phase_cnt;
            logic                       de_rise;

            assign de_rise = vid.i_hve[2] & ~prev_de;

            always_ff @(posedge hdmi_clk) begin
                if (reset) begin
                    dly       <= '0;
                    prev_de   <= 1'b0;
                    phase_cnt <= '0;
                end else begin
                    dly     <= {dly[DELAY_LEN-2:0], {vid.i_hve, vid.i_rgb}};
                    prev_de <= vid.i_hve[2];
                    if (de_rise) begin
                        phase_cnt <= PHASE_LOAD;
                    end else if (phase_cnt != 4'd0) begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
            end

            // The delayed cycle presented at the rise edge is phase 10;
            // after that the counter runs one ahead of the presented cycle.
            assign phase = de_rise ? PHASE_LOAD :
                           (phase_cnt > 4'd1) ? (phase_cnt - 4'd1) : 4'd0;
            assign {hve_d, rgb_d} = dly[DELAY_LEN-1];
        end else begin : g_dvi
            assign hve_d = vid.i_hve;
            assign rgb_d = vid.i_rgb;
            assign phase = 4'd0;
        end
    endgenerate

    // Delayed video always wins over preamble/guard.
    always_comb begin
        sel   = SEL_CTRL;
        ctl_g = 2'b00;
        if (hve_d[2]) begin
            sel = SEL_VIDEO;
        end else if ((phase != 4'd0) && (phase <= GUARD_PHASES)) begin
            sel = SEL_GUARD;
        end else if (phase > GUARD_PHASES) begin
            ctl_g = 2'b01;
        end
    end

    tmds_channel #(.GUARD_CHAR(GB_CH0)) u_ch0 (
        .clk   (hdmi_clk),
        .reset (reset),
        .data  (rgb_d[7:0]),
        .de    (hve_d[2]),
        .ctrl  (hve_d[1:0]),
        .sel   (sel),
        .tmds  (vid.o_tmds_ch0)
    );

    tmds_channel #(.GUARD_CHAR(GB_CH1)) u_ch1 (
        .clk   (hdmi_clk),
        .reset (reset),
        .data  (rgb_d[15:8]),
        .de    (hve_d[2]),
        .ctrl  (ctl_g),
        .sel   (sel),
        .tmds  (vid.o_tmds_ch1)
    );

    tmds_channel #(.GUARD_CHAR(GB_CH2)) u_ch2 (
        .clk   (hdmi_clk),
        .reset (reset),
        .data  (rgb_d[23:16]),
        .de    (hve_d[2]),
        .ctrl  (2'b00),
        .sel   (sel),
        .tmds  (vid.o_tmds_ch2)
    );

endmodule
